// File: rtl/binary_decoder_scan_if.sv
// Handshake and decoded-output bundle for binary_decoder_scan.
// master drives control and code; slave is the decoder itself.
interface binary_decoder_scan_if #(
  parameter int unsigned N = 3
);
  localparam int unsigned Width = 2**N;

  logic             en;
  logic             mode;
  logic             in_valid;
  logic [N-1:0]     in_code;
  logic             in_ready;
  logic [Width-1:0] out_code;
  logic [N-1:0]     out_idx;
  logic             out_valid;
  logic             wrap;

  modport master (
    output en, mode, in_valid, in_code,
    input  in_ready, out_code, out_idx, out_valid, wrap
  );

  modport slave (
    input  en, mode, in_valid, in_code,
    output in_ready, out_code, out_idx, out_valid, wrap
  );
endinterface

// File: rtl/binary_decoder_scan.sv
// Registered N-to-2^N one-hot decoder: DIRECT decodes handshaked codes,
// SCAN walks the outputs on an internal timer for display multiplexing.
module binary_decoder_scan #(
  parameter int unsigned N          = 3,
  parameter bit          ACTIVE_LOW = 1'b0,
  parameter int unsigned TICK_DIV   = 4,
  parameter int unsigned SCAN_LAST  = 2**N - 1
) (
  input logic                  clk,
  input logic                  rst_n,
  binary_decoder_scan_if.slave bus
);
  localparam int unsigned Width = 2**N;
  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);
  localparam logic [N-1:0] IdxLast = N'(SCAN_LAST);

  typedef enum logic [1:0] {StIdle, StDirect, StScan} state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] code_q, code_d;   // active-high internally
  logic [N-1:0]     idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic [TickW-1:0] tick_q, tick_d;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    tick_d  = tick_q;
    if (!bus.en) begin
      state_d = StIdle;
      code_d  = '0;
      idx_d   = '0;
      valid_d = 1'b0;
      tick_d  = '0;
    end else if (bus.mode) begin
      state_d = StScan;
      valid_d = 1'b1;
      if (state_q != StScan) begin
        // Entry restarts the scan; any previous position is discarded.
        idx_d  = '0;
        code_d = Width'(1);
        tick_d = '0;
      end else if (tick_q == TickMax) begin
        tick_d = '0;
        if (idx_q == IdxLast) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q + N'(1);
        end
        code_d = Width'(1) << idx_d;
      end else begin
        tick_d = tick_q + TickW'(1);
      end
    end else begin
      state_d = StDirect;
      if (state_q != StDirect) begin
        code_d  = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        tick_d  = '0;
      end else if (bus.in_valid) begin
        code_d  = Width'(1) << bus.in_code;
        idx_d   = bus.in_code;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      code_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.in_ready  = (state_q == StDirect);
  assign bus.out_code  = ACTIVE_LOW ? ~code_q : code_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_valid = valid_q;
  assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_binary_decoder_scan.sv
// Scoreboard bench: stimulus pushes expected outputs, per-DUT monitors pop on out_valid.
// u0 default config, u1 SCAN_LAST=4/TICK_DIV=1, u2 ACTIVE_LOW=1.
module tb_binary_decoder_scan;
  typedef struct {
    logic [7:0] code;
    logic [2:0] idx;
    logic       wrap;
    logic       ready;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  int   ix;
  exp_t q0[$], q1[$], q2[$];
  exp_t e0, e1, e2;
  logic [7:0] scan4_codes [5];

  binary_decoder_scan_if #(.N(3)) b0 ();
  binary_decoder_scan_if #(.N(3)) b1 ();
  binary_decoder_scan_if #(.N(3)) b2 ();

  binary_decoder_scan #(.N(3), .ACTIVE_LOW(1'b0), .TICK_DIV(4), .SCAN_LAST(7)) u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0.slave)
  );
  binary_decoder_scan #(.N(3), .ACTIVE_LOW(1'b0), .TICK_DIV(1), .SCAN_LAST(4)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );
  binary_decoder_scan #(.N(3), .ACTIVE_LOW(1'b1), .TICK_DIV(4), .SCAN_LAST(7)) u2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic push0(input logic [7:0] c, input logic [2:0] i, input logic w, input logic r);
    q0.push_back('{code: c, idx: i, wrap: w, ready: r});
  endtask
  task automatic push1(input logic [7:0] c, input logic [2:0] i, input logic w, input logic r);
    q1.push_back('{code: c, idx: i, wrap: w, ready: r});
  endtask
  task automatic push2(input logic [7:0] c, input logic [2:0] i, input logic w, input logic r);
    q2.push_back('{code: c, idx: i, wrap: w, ready: r});
  endtask

  // Monitors: sample 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    if (b0.out_valid) begin
      if (q0.size() == 0) chk("mon0_unexpected", {19'd0, b0.out_code, b0.out_idx, b0.wrap, b0.in_ready}, 32'hDEAD);
      else begin
        e0 = q0.pop_front();
        chk("mon0", {19'd0, b0.out_code, b0.out_idx, b0.wrap, b0.in_ready},
            {19'd0, e0.code, e0.idx, e0.wrap, e0.ready});
      end
    end
  end
  always @(posedge clk) begin
    #1;
    if (b1.out_valid) begin
      if (q1.size() == 0) chk("mon1_unexpected", {19'd0, b1.out_code, b1.out_idx, b1.wrap, b1.in_ready}, 32'hDEAD);
      else begin
        e1 = q1.pop_front();
        chk("mon1", {19'd0, b1.out_code, b1.out_idx, b1.wrap, b1.in_ready},
            {19'd0, e1.code, e1.idx, e1.wrap, e1.ready});
      end
    end
  end
  always @(posedge clk) begin
    #1;
    if (b2.out_valid) begin
      if (q2.size() == 0) chk("mon2_unexpected", {19'd0, b2.out_code, b2.out_idx, b2.wrap, b2.in_ready}, 32'hDEAD);
      else begin
        e2 = q2.pop_front();
        chk("mon2", {19'd0, b2.out_code, b2.out_idx, b2.wrap, b2.in_ready},
            {19'd0, e2.code, e2.idx, e2.wrap, e2.ready});
      end
    end
  end

  // Stimulus: drive at a falling edge, push what the next rising edge must produce.
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    scan4_codes = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
    rst_n = 1'b0;
    b0.en = 1'b0; b0.mode = 1'b0; b0.in_valid = 1'b0; b0.in_code = '0;
    b1.en = 1'b0; b1.mode = 1'b0; b1.in_valid = 1'b0; b1.in_code = '0;
    b2.en = 1'b0; b2.mode = 1'b0; b2.in_valid = 1'b0; b2.in_code = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", {20'd0, b0.out_code, b0.out_idx, b0.out_valid, b0.wrap, b0.in_ready}, 32'd0);
    chk("reset_active_low", {24'd0, b2.out_code}, 32'h0000_00FF);
    rst_n = 1'b1;
    @(negedge clk);

    // DIRECT entry: not valid, inactive, ready from registered state.
    b0.en = 1'b1; b0.mode = 1'b0;
    @(negedge clk);
    chk("direct_entry", {22'd0, b0.in_ready, b0.out_valid, b0.out_code}, {22'd0, 1'b1, 1'b0, 8'h00});
    for (int i = 0; i < 8; i++) begin
      b0.in_valid = 1'b1;
      b0.in_code  = 3'(i);
      push0(8'(1 << i), 3'(i), 1'b0, 1'b1);
      @(negedge clk);
    end
    b0.in_code = 3'd5;
    push0(8'h20, 3'd5, 1'b0, 1'b1);
    @(negedge clk);
    b0.in_valid = 1'b0;
    b0.in_code  = 3'd3;
    repeat (10) begin
      push0(8'h20, 3'd5, 1'b0, 1'b1);
      @(negedge clk);
    end

    // SCAN: 4 clocks per step, wrap 7 -> 0; stop at idx 3.
    b0.mode = 1'b1;
    for (int s = 0; s < 46; s++) begin
      if (s == 2) begin
        b0.in_valid = 1'b1;
        b0.in_code  = 3'd6;
      end
      ix = (s / 4) % 8;
      push0(8'(1 << ix), 3'(ix), (s > 0) && (s % 32 == 0), 1'b0);
      @(negedge clk);
    end
    b0.in_valid = 1'b0;
    b0.en = 1'b0;
    @(negedge clk);
    chk("idle_after_scan", {20'd0, b0.out_code, b0.out_valid, b0.wrap, b0.in_ready, b0.out_idx},
        32'd0);
    @(negedge clk);
    chk("idle_hold", {22'd0, b0.out_code, b0.out_valid, b0.wrap}, 32'd0);
    b0.en = 1'b1;
    for (int s = 0; s < 6; s++) begin
      ix = s / 4;
      push0(8'(1 << ix), 3'(ix), 1'b0, 1'b0);
      @(negedge clk);
    end
    b0.en = 1'b0;
    @(negedge clk);

    // SCAN_LAST=4, TICK_DIV=1: step every clock, wrap every 5th.
    b1.en = 1'b1; b1.mode = 1'b1;
    for (int s = 0; s < 12; s++) begin
      push1(scan4_codes[s % 5], 3'(s % 5), (s > 0) && (s % 5 == 0), 1'b0);
      @(negedge clk);
    end
    b1.en = 1'b0;
    @(negedge clk);

    // ACTIVE_LOW decode, then asynchronous reset mid-scan.
    b2.en = 1'b1; b2.mode = 1'b0;
    @(negedge clk);
    chk("al_direct_entry", {24'd0, b2.out_code}, 32'h0000_00FF);
    b2.in_valid = 1'b1; b2.in_code = 3'd2;
    push2(8'hFB, 3'd2, 1'b0, 1'b1);
    @(negedge clk);
    b2.in_valid = 1'b0;
    push2(8'hFB, 3'd2, 1'b0, 1'b1);
    @(negedge clk);
    b2.mode = 1'b1;
    push2(8'hFE, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    push2(8'hFE, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_al", {20'd0, b2.out_code, b2.out_valid, b2.out_idx}, {20'd0, 8'hFF, 1'b0, 3'd0});
    @(negedge clk);
    chk("reset_held_al", {23'd0, b2.out_code, b2.out_valid}, {23'd0, 8'hFF, 1'b0});
    b2.en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    chk("queues_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
